// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM states, default PWM timing and window helper for the PWM blocks.
package pwm_pkg;
    typedef enum logic [2:0] {
        INICIAL,
        ESPERA_SUBIDA,
        MEDE_ALTO,
        MEDE_BAIXO,
        PUBLICA
    } estado_t;

    localparam int CONF_PERIODO = 1250;
    localparam int LARGURA_00   = 0;
    localparam int LARGURA_01   = 50;
    localparam int LARGURA_10   = 500;
    localparam int LARGURA_11   = 1000;
    localparam int TOLERANCIA   = 10;
    localparam int CONTADOR_N   = 12;

    function automatic logic na_janela(input int valor, input int alvo, input int tol);
        return valor >= alvo - tol && valor <= alvo + tol;
    endfunction
endpackage

// File: rtl/detector_borda.sv
// detector_borda: two-flop synchronizer plus history flop producing one-cycle edge pulses.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic pwm,
    output logic subida,
    output logic descida,
    output logic nivel
);
    logic [2:0] s;

    always_ff @(posedge clock or negedge reset)
        if (!reset) s <= '0;
        else s <= {s[1:0], pwm};

    assign subida  = s[1] & ~s[2];
    assign descida = ~s[1] & s[2];
    assign nivel   = s[1];
endmodule

// File: rtl/medidor_pwm.sv
// medidor_pwm: measures high time and period of an async PWM line and decodes its width code.
module medidor_pwm
    import pwm_pkg::*;
#(
    parameter int conf_periodo = CONF_PERIODO,
    parameter int largura_00   = LARGURA_00,
    parameter int largura_01   = LARGURA_01,
    parameter int largura_10   = LARGURA_10,
    parameter int largura_11   = LARGURA_11,
    parameter int tolerancia   = TOLERANCIA,
    parameter int N            = CONTADOR_N
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pwm,
    output logic [1:0]   largura,
    output logic [N-1:0] medida_alto,
    output logic [N-1:0] medida_periodo,
    output logic         pronto,
    output logic         erro
);
    localparam int LIMITE = 2 * conf_periodo;

    estado_t estado, prox;
    logic subida, descida, nivel, per_ok, valido, estourou, preso;
    logic [3:0] casa;
    logic [1:0] codigo, prox_largura;
    logic [N-1:0] alto, periodo, ocioso;
    logic [N-1:0] prox_alto, prox_periodo, prox_ocioso, prox_malto, prox_mper;
    logic prox_pronto, prox_erro;

    function automatic logic [N-1:0] sat(input logic [N-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    detector_borda u_borda (
        .clock   (clock),
        .reset   (reset),
        .pwm     (pwm),
        .subida  (subida),
        .descida (descida),
        .nivel   (nivel)
    );

    // Lowest matching code wins should the windows ever overlap.
    assign casa = {na_janela(int'(alto), largura_11, tolerancia),
                   na_janela(int'(alto), largura_10, tolerancia),
                   na_janela(int'(alto), largura_01, tolerancia),
                   na_janela(int'(alto), largura_00, tolerancia)};
    assign codigo   = casa[0] ? 2'd0 : casa[1] ? 2'd1 : casa[2] ? 2'd2 : 2'd3;
    assign per_ok   = na_janela(int'(periodo), conf_periodo, tolerancia);
    assign valido   = per_ok && |casa;
    assign estourou = int'(ocioso) >= LIMITE - 1 && !(subida || descida) &&
                      (estado == ESPERA_SUBIDA || estado == MEDE_ALTO || estado == MEDE_BAIXO);
    assign preso    = estado == MEDE_ALTO || nivel;

    always_ff @(posedge clock or negedge reset)
        if (!reset) estado <= INICIAL;
        else estado <= prox;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            alto           <= '0;
            periodo        <= '0;
            ocioso         <= '0;
            largura        <= '0;
            medida_alto    <= '0;
            medida_periodo <= '0;
            pronto         <= 1'b0;
            erro           <= 1'b0;
        end else begin
            alto           <= prox_alto;
            periodo        <= prox_periodo;
            ocioso         <= prox_ocioso;
            largura        <= prox_largura;
            medida_alto    <= prox_malto;
            medida_periodo <= prox_mper;
            pronto         <= prox_pronto;
            erro           <= prox_erro;
        end

    always_comb begin
        prox         = estado;
        prox_alto    = alto;
        prox_periodo = periodo;
        prox_ocioso  = (subida || descida) ? '0 : sat(ocioso);
        prox_largura = largura;
        prox_malto   = medida_alto;
        prox_mper    = medida_periodo;
        prox_pronto  = 1'b0;
        prox_erro    = erro;
        case (estado)
            INICIAL: begin
                prox_alto    = '0;
                prox_periodo = '0;
                prox_ocioso  = '0;
                prox         = ESPERA_SUBIDA;
            end
            ESPERA_SUBIDA: begin
                prox_alto    = subida ? '0 : alto;
                prox_periodo = subida ? '0 : sat(periodo);
                prox         = subida ? MEDE_ALTO : ESPERA_SUBIDA;
            end
            MEDE_ALTO: begin
                prox_alto    = sat(alto);
                prox_periodo = sat(periodo);
                prox         = descida ? MEDE_BAIXO : MEDE_ALTO;
            end
            MEDE_BAIXO: begin
                prox_periodo = sat(periodo);
                prox         = subida ? PUBLICA : MEDE_BAIXO;
            end
            PUBLICA: begin
                prox_pronto  = 1'b1;
                prox_malto   = alto;
                prox_mper    = periodo;
                prox_erro    = !valido;
                prox_largura = valido ? codigo : largura;
                // This cycle already belongs to the high phase opened by the closing rise.
                prox_alto    = N'(1);
                prox_periodo = N'(1);
                prox         = MEDE_ALTO;
            end
            default: prox = INICIAL;
        endcase
        if (estourou) begin
            prox         = ESPERA_SUBIDA;
            prox_alto    = '0;
            prox_periodo = '0;
            prox_ocioso  = '0;
            prox_pronto  = 1'b1;
            prox_erro    = preso;
            prox_largura = preso ? largura : 2'd0;
            prox_malto   = preso ? medida_alto : '0;
            prox_mper    = preso ? medida_periodo : '0;
        end
    end
endmodule

// File: tb/tb_medidor_pwm.sv
// tb_medidor_pwm: directed and randomized PWM trains scored against a period/width reference model.
module tb_medidor_pwm;
    logic clk = 1'b0, reset = 1'b0, pwm = 1'b0;
    logic [1:0] largura;
    logic [11:0] medida_alto, medida_periodo;
    logic pronto, erro;

    typedef struct {
        int larg;
        int alto;
        int per;
        int erro;
        bit chk_med;
        int quando;
    } esp_t;

    esp_t fila[$];
    int n_testes = 0, n_falhas = 0, ciclo = 0, ult = 0;
    int tr_h[$], tr_l[$];

    medidor_pwm dut (
        .clock          (clk),
        .reset          (reset),
        .pwm            (pwm),
        .largura        (largura),
        .medida_alto    (medida_alto),
        .medida_periodo (medida_periodo),
        .pronto         (pronto),
        .erro           (erro)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic checa(input string nome, input int real_v, input int esp);
        n_testes++;
        if (real_v != esp) begin
            n_falhas++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, real_v, esp, ciclo);
        end
    endtask

    function automatic void espera(input int larg, input int alto, input int per, input int er,
                                   input bit chk, input int quando);
        fila.push_back('{larg, alto, per, er, chk, quando});
    endfunction

    // Reference: a period is closed by the next rise; classify its high time and length.
    function automatic void fecha(input int h, input int l);
        int ws[4] = '{0, 50, 500, 1000};
        int cod = -1;
        bit ruim;
        for (int i = 3; i >= 0; i--)
            if ((h > ws[i] ? h - ws[i] : ws[i] - h) <= 10) cod = i;
        ruim = cod < 0 || h + l < 1240 || h + l > 1260;
        if (!ruim) ult = cod;
        espera(ult, h, h + l, int'(ruim), 1'b1, -1);
    endfunction

    task automatic nivel_por(input logic v, input int n);
        pwm = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic zera_apos(input int n);
        espera(0, 0, 0, 0, 1'b1, ciclo + 2503);
        ult = 0;
        nivel_por(1'b0, n);
    endtask

    task automatic rodar_trem();
        for (int i = 0; i < tr_h.size(); i++) begin
            if (i > 0) fecha(tr_h[i-1], tr_l[i-1]);
            nivel_por(1'b1, tr_h[i]);
            if (i < tr_h.size() - 1) nivel_por(1'b0, tr_l[i]);
        end
        zera_apos(2600);
        tr_h.delete();
        tr_l.delete();
    endtask

    task automatic checa_zero(input string nome);
        checa({nome, "_largura"}, int'(largura), 0);
        checa({nome, "_alto"}, int'(medida_alto), 0);
        checa({nome, "_periodo"}, int'(medida_periodo), 0);
        checa({nome, "_pronto"}, int'(pronto), 0);
        checa({nome, "_erro"}, int'(erro), 0);
    endtask

    initial forever begin
        esp_t e;
        @(posedge clk);
        #1;
        if (reset && pronto) begin
            if (fila.size() == 0) checa("pronto_inesperado", 1, 0);
            else begin
                e = fila.pop_front();
                checa("largura", int'(largura), e.larg);
                checa("erro", int'(erro), e.erro);
                if (e.chk_med) begin
                    checa("medida_alto", int'(medida_alto), e.alto);
                    checa("medida_periodo", int'(medida_periodo), e.per);
                end
                if (e.quando >= 0)
                    checa("instante", (ciclo - e.quando <= 8 && e.quando - ciclo <= 8) ? e.quando : ciclo,
                          e.quando);
            end
        end
    end

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: run still active at cycle %0d, expected finish", ciclo);
        $fatal(1);
    end

    initial begin
        int noms[4] = '{50, 500, 1000, 700};
        int h, p;
        repeat (3) @(negedge clk);
        checa_zero("reset");
        reset = 1'b1;
        espera(0, 0, 0, 0, 1'b1, ciclo + 2501);
        espera(0, 0, 0, 0, 1'b1, ciclo + 5001);
        nivel_por(1'b0, 5100);
        repeat (5) begin tr_h.push_back(50); tr_l.push_back(1200); end
        rodar_trem();
        repeat (3) begin tr_h.push_back(500); tr_l.push_back(750); end
        repeat (3) begin tr_h.push_back(1000); tr_l.push_back(250); end
        rodar_trem();
        tr_h = '{50, 700, 50, 50, 50};
        tr_l = '{1200, 550, 1200, 1350, 1200};
        rodar_trem();
        espera(ult, 0, 0, 1, 1'b0, ciclo + 2503);
        nivel_por(1'b1, 3000);
        zera_apos(2600);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) fecha(50, 1200);
            nivel_por(1'b1, 50);
            nivel_por(1'b0, 1200);
        end
        fecha(50, 1200);
        nivel_por(1'b1, 20);
        reset = 1'b0;
        pwm = 1'b0;
        #1;
        checa_zero("reset_meio");
        ult = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        nivel_por(1'b0, 1200);
        repeat (3) begin tr_h.push_back(500); tr_l.push_back(750); end
        rodar_trem();
        repeat (12) begin
            h = noms[$urandom_range(0, 3)] + int'($urandom_range(0, 28)) - 14;
            p = 1250 + int'($urandom_range(0, 28)) - 14;
            tr_h.push_back(h);
            tr_l.push_back(p - h);
        end
        rodar_trem();
        repeat (20) @(negedge clk);
        checa("fila_vazia", fila.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end
endmodule

// File: doc/medidor_pwm.md
MEDIDOR_PWM -- requirements
Module: medidor_pwm

Interface
REQ-001 Parameter conf_periodo, default 1250: nominal PWM period in clock cycles (25 us at 50 MHz).
REQ-002 Parameter largura_00, default 0: pulse width for code 00, i.e. no pulse.
REQ-003 Parameter largura_01, default 50: pulse width in cycles for code 01.
REQ-004 Parameter largura_10, default 500: pulse width in cycles for code 10.
REQ-005 Parameter largura_11, default 1000: pulse width in cycles for code 11.
REQ-006 Parameter tolerancia, default 10: allowed +/- deviation in cycles for widths and period.
REQ-007 Parameter N, default 12: counter width; must satisfy 2^N > 2*conf_periodo.
REQ-008 Port clock, input, 1 bit: single system clock, rising edge.
REQ-009 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 Port pwm, input, 1 bit: asynchronous PWM line under measurement.
REQ-011 Port largura, output, 2 bits: last decoded width code.
REQ-012 Port medida_alto, output, N bits: last measured high time in cycles.
REQ-013 Port medida_periodo, output, N bits: last measured period in cycles.
REQ-014 Port pronto, output, 1 bit: one-cycle pulse when a new result is published.
REQ-015 Port erro, output, 1 bit: level output; 1 means the last result was invalid.

Function
REQ-016 pwm shall pass through a 2-FF synchronizer plus one edge-detect register, giving a fixed 3-cycle latency that is identical for rising and falling edges.
REQ-017 FSM states: INICIAL, ESPERA_SUBIDA, MEDE_ALTO, MEDE_BAIXO, PUBLICA.
REQ-018 INICIAL: clear counters, then go to ESPERA_SUBIDA on the next cycle.
REQ-019 ESPERA_SUBIDA: count cycles; on a detected rise, zero both counters and go to MEDE_ALTO.
REQ-020 MEDE_ALTO: increment the high and period counters each cycle; on a detected fall, freeze the high counter and go to MEDE_BAIXO.
REQ-021 MEDE_BAIXO: increment the period counter; on a detected rise, go to PUBLICA.
REQ-022 Result of a measurement: medida_alto = cycles from rise detect to fall detect; medida_periodo = cycles from rise detect to next rise detect (exact, no off-by-one).
REQ-023 PUBLICA, lasting one cycle:
- latch the outputs and assert pronto;
- erro=1 if |periodo - conf_periodo| > tolerancia, or if the high time matches no largura_xx within +/- tolerancia;
- otherwise erro=0 and largura = the matching code;
- re-enter MEDE_ALTO with counters already at 1, so the rise that closed one period opens the next.
REQ-024 When erro=1, largura shall hold its previous value.
REQ-025 Timeout, no edge for 2*conf_periodo cycles in any measuring state:
- in ESPERA_SUBIDA or MEDE_BAIXO with the line low: publish largura=00, medida_alto=0, medida_periodo=0, erro=0;
- in MEDE_ALTO, meaning the line is stuck high: publish erro=1.
- In both cases pulse pronto, return to ESPERA_SUBIDA, and repeat the publish every 2*conf_periodo cycles while the condition persists.
REQ-026 Counters shall saturate at 2^N-1 and never wrap.
REQ-027 A fall detected outside MEDE_ALTO, or a rise in MEDE_ALTO (impossible after sync), shall be ignored.

Reset
REQ-028 reset=0 shall asynchronously force:
- FSM to INICIAL;
- synchronizer flops to 0;
- all counters to 0;
- largura=00, medida_alto=0, medida_periodo=0, pronto=0, erro=0.
REQ-029 A reset during a measurement shall discard the partial measurement; no pronto follows until a new full period is measured, or until a timeout.

Structure
REQ-030 The FSM state encoding and the default timing constants shall live in a shared package, pwm_pkg, reused with circuito_pwm.
REQ-031 Synchronizer and edge detector shall be one sub-module, detector_borda, with outputs subida and descida, each a one-cycle pulse.
REQ-032 Classification shall be combinational, using parallel compares against the four width windows.

Verification
REQ-033 Scenario: 50 cycles high / 1200 low, repeated -> from the second rise, pronto every 1250 cycles; largura=01, medida_alto=50, medida_periodo=1250, erro=0.
REQ-034 Scenario: sweep widths 500 then 1000 -> largura 10 then 11; first corrected result on the first full period after the change.
REQ-035 Scenario: line held low for 2600 cycles after reset -> one pronto at cycle 2500 after ESPERA_SUBIDA entry; largura=00, erro=0.
REQ-036 Scenario: width 700 at period 1250 -> erro=1, largura unchanged; period 1400 at width 50 -> erro=1.
REQ-037 Scenario: line stuck high for 3000 cycles -> pronto with erro=1 at 2500 cycles after the rise.
REQ-038 Scenario: reset pulsed low mid-high-phase -> outputs zero immediately; next pronto only after a complete new period.
